llc_lookup_stage: RTL and testbench
===================================

Name: llc_lookup_stage

Overview:
Pipelined tag-lookup stage between the local-memory read FIFO (mem-lookup packets) and the lookup-to-process FIFO in the LLC core.
- Input per entry: set, requested tag, flattened per-way tags/states, current evict way and the 7 decoder request flags.
- Output per entry: hit/way/evict decision plus all pass-through fields.
- Two-register pipeline with valid/ready handshakes on both sides. No combinational ready path from output to input beyond one AND term.

Parameters:
WAYS, 16, number of LLC ways (power of two, >=2)
WAY_BITS, 4, log2(WAYS)
TAG_BITS, 14, LLC tag width
STATE_BITS, 3, per-way coherence state width
SET_BITS, 9, LLC set index width
FLAG_BITS, 7, decoder flags {rst_resume, flush_resume, req_resume, rst_get, req_get, rsp_get, dma_req_get}, MSB first

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high (see interface note below)
in_valid  in  1  upstream entry valid
in_ready  out  1  stage accepts entry
in_set  in  SET_BITS  set index
in_tag  in  TAG_BITS  requested tag
in_tags  in  WAYS*TAG_BITS  way i tag at bits [i*TAG_BITS +: TAG_BITS]
in_states  in  WAYS*STATE_BITS  way i state, same packing
in_evict_way  in  WAY_BITS  round-robin evict pointer for set
in_flags  in  FLAG_BITS  decoder flags
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_set  out  SET_BITS  pass-through
out_tag  out  TAG_BITS  pass-through
out_flags  out  FLAG_BITS  pass-through
out_hit  out  1  tag match in non-INVALID way
out_way  out  WAY_BITS  selected way
out_evict  out  1  selected way must be evicted
out_empty_found  out  1  an INVALID way was selected
lookups_cnt  out  16  completed handshakes, wraps at 2^16

Interface note (already decided): one clock, clk; reset is synchronous and active-high, on port rst.

Behaviour:
- Reset (rst high at posedge):
  - out_valid=0, both pipeline valids=0, lookups_cnt=0.
  - All other output registers are 0.
  - in_ready is 1 in the first cycle after reset.
  - Reset mid-operation drops in-flight entries silently.
- Stage S1 (register on in_valid&&in_ready) captures:
  - set, tag and flags;
  - hit vector h[i] = (tags[i]==in_tag) && (state[i]!=INVALID);
  - invalid vector v[i] = (state[i]==INVALID);
  - evict_way.
- Stage S2 (register on S1 advance) selects, in priority order:
  1. flags rst_resume or flush_resume set: way=0, hit=0, evict=0, empty_found=0 (bypass).
  2. Any h[i]: hit=1, way = lowest i with h[i]. More than one hit is illegal; a simulation assertion flags it.
  3. Any v[i]: way = first i with v[i], scanning evict_way, evict_way+1, … modulo WAYS. empty_found=1, evict=0.
  4. Otherwise: way=evict_way, evict=1.
- Way arithmetic is WAY_BITS wide, modulo WAYS. Wrap from WAYS-1 to 0 is required.
- INVALID encodes as 0, held in the shared package.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = s1_valid && s2_adv.
  - in_ready = !s1_valid || s2_adv.
  - out_valid = s2_valid.
  - Outputs are held stable while out_valid && !out_ready.
- Latency 2 cycles in to out. Throughput 1 entry/cycle when out_ready stays high.
- Full condition: both stages valid and out_ready low, so in_ready=0. Capacity is 2 entries; no loss and no duplication.
- Simultaneous accept at input and drain at output in one cycle is required. The pipeline stays full at throughput 1.
- lookups_cnt increments on out_valid&&out_ready and wraps 0xFFFF to 0.

Decomposition:
- Shared package llc_lookup_pkg:
  - INVALID constant;
  - flag bit indices;
  - packed typedefs for the S1 and S2 payloads.
- One sub-module, llc_rr_way_select: combinational rotate-and-priority-encode (vector, start way) returning found and way. Used for the invalid-way search.

Test Plan:
- After rst: in_ready=1, out_valid=0, lookups_cnt=0.
- Hit:
  - Stimulus: in_tag=0x123, way 5 tag 0x123 state 2, others INVALID, evict_way=9.
  - Response: two cycles later out_hit=1, out_way=5, out_evict=0.
- Invalid-way wrap:
  - Stimulus: no match, ways 0..15 valid except way 2 INVALID, evict_way=14.
  - Response: out_way=2, out_empty_found=1, out_evict=0.
- Full eviction:
  - Stimulus: all ways valid, no match, evict_way=7.
  - Response: out_way=7, out_evict=1, out_hit=0.
- Flush bypass:
  - Stimulus: flags=7'b0100000 with a matching tag in way 3.
  - Response: out_way=0, out_hit=0, out_evict=0.
- Backpressure:
  - Stimulus: 5 back-to-back entries, out_ready low for cycles 2–6.
  - Response: in_ready drops after 2 entries held. Results emerge in order, unchanged while stalled. lookups_cnt=5.
  - Variant: rst asserted mid-stream gives out_valid=0 on the next cycle.

Source files
------------

// File: rtl/llc_lookup_pkg.sv
// Shared widths, coherence-state encoding, decoder flag positions and the
// pipeline payload layouts of the LLC tag-lookup stage.
package llc_lookup_pkg;

    localparam int WAYS       = 16;
    localparam int WAY_BITS   = 4;
    localparam int TAG_BITS   = 14;
    localparam int STATE_BITS = 3;
    localparam int SET_BITS   = 9;
    localparam int FLAG_BITS  = 7;

    localparam logic [STATE_BITS-1:0] INVALID = '0;

    // Decoder flags arrive MSB first: {rst_resume, flush_resume, req_resume,
    // rst_get, req_get, rsp_get, dma_req_get}.
    localparam int FLAG_RST_RESUME   = 6;
    localparam int FLAG_FLUSH_RESUME = 5;
    localparam int FLAG_REQ_RESUME   = 4;
    localparam int FLAG_RST_GET      = 3;
    localparam int FLAG_REQ_GET      = 2;
    localparam int FLAG_RSP_GET      = 1;
    localparam int FLAG_DMA_REQ_GET  = 0;

    typedef struct packed {
        logic [SET_BITS-1:0]  set_idx;
        logic [TAG_BITS-1:0]  tag;
        logic [FLAG_BITS-1:0] flags;
        logic [WAYS-1:0]      hit_vec;
        logic [WAYS-1:0]      inv_vec;
        logic [WAY_BITS-1:0]  evict_way;
    } s1_payload_t;

    typedef struct packed {
        logic [SET_BITS-1:0]  set_idx;
        logic [TAG_BITS-1:0]  tag;
        logic [FLAG_BITS-1:0] flags;
        logic                 hit;
        logic [WAY_BITS-1:0]  way;
        logic                 evict;
        logic                 empty_found;
    } s2_payload_t;

    function automatic logic is_bypass(input logic [FLAG_BITS-1:0] flags);
        return flags[FLAG_RST_RESUME] | flags[FLAG_FLUSH_RESUME];
    endfunction

endpackage

// File: rtl/llc_lookup_stage_if.sv
// Upstream (mem-lookup packet) and downstream (lookup-to-process) handshake
// bundle of the lookup stage.
interface llc_lookup_stage_if;
    import llc_lookup_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [SET_BITS-1:0]        in_set;
    logic [TAG_BITS-1:0]        in_tag;
    logic [WAYS*TAG_BITS-1:0]   in_tags;
    logic [WAYS*STATE_BITS-1:0] in_states;
    logic [WAY_BITS-1:0]        in_evict_way;
    logic [FLAG_BITS-1:0]       in_flags;

    logic                       out_valid;
    logic                       out_ready;
    logic [SET_BITS-1:0]        out_set;
    logic [TAG_BITS-1:0]        out_tag;
    logic [FLAG_BITS-1:0]       out_flags;
    logic                       out_hit;
    logic [WAY_BITS-1:0]        out_way;
    logic                       out_evict;
    logic                       out_empty_found;

    modport master (
        output in_valid, in_set, in_tag, in_tags, in_states, in_evict_way, in_flags,
        output out_ready,
        input  in_ready,
        input  out_valid, out_set, out_tag, out_flags, out_hit, out_way, out_evict,
        input  out_empty_found
    );

    modport slave (
        input  in_valid, in_set, in_tag, in_tags, in_states, in_evict_way, in_flags,
        input  out_ready,
        output in_ready,
        output out_valid, out_set, out_tag, out_flags, out_hit, out_way, out_evict,
        output out_empty_found
    );

endinterface

// File: rtl/llc_rr_way_select.sv
// Round-robin way search: first set bit of vec_i scanning from start_i upward,
// wrapping modulo WAYS.
module llc_rr_way_select
    import llc_lookup_pkg::*;
(
    input  logic [WAYS-1:0]     vec_i,
    input  logic [WAY_BITS-1:0] start_i,
    output logic                found_o,
    output logic [WAY_BITS-1:0] way_o
);

    logic [WAYS-1:0]     rot;
    logic [WAY_BITS-1:0] offset;

    // rot[k] is way (start + k) mod WAYS; the WAY_BITS-wide add gives the wrap.
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_rot
            logic [WAY_BITS-1:0] idx;
            assign idx     = start_i + WAY_BITS'(gi);
            assign rot[gi] = vec_i[idx];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int k = WAYS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offset = WAY_BITS'(k);
            end
        end
    end

    assign found_o = |rot;
    assign way_o   = start_i + offset;

endmodule

// File: rtl/llc_lookup_stage.sv
// Two-register LLC tag lookup: S1 compares tags/states, S2 picks the hit,
// empty or victim way, with valid/ready flow control on both sides.
module llc_lookup_stage
    import llc_lookup_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    llc_lookup_stage_if.slave    bus,
    output logic [15:0]          lookups_cnt
);

    s1_payload_t s1_q, s1_d;
    s2_payload_t s2_q, s2_d;
    logic        s1_valid_q, s1_valid_d;
    logic        s2_valid_q, s2_valid_d;
    logic [15:0] cnt_q;

    logic s2_adv, s1_adv, in_fire, out_fire;

    assign s2_adv      = !s2_valid_q || bus.out_ready;
    assign s1_adv      = s1_valid_q && s2_adv;
    assign bus.in_ready = !s1_valid_q || s2_adv;
    assign in_fire     = bus.in_valid && bus.in_ready;
    assign out_fire    = s2_valid_q && bus.out_ready;

    // S1: per-way match and invalid vectors.
    logic [WAYS-1:0] hit_vec, inv_vec;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [TAG_BITS-1:0]   way_tag;
            logic [STATE_BITS-1:0] way_state;
            assign way_tag     = bus.in_tags[gi*TAG_BITS +: TAG_BITS];
            assign way_state   = bus.in_states[gi*STATE_BITS +: STATE_BITS];
            assign inv_vec[gi] = (way_state == INVALID);
            assign hit_vec[gi] = (way_tag == bus.in_tag) && !inv_vec[gi];
        end
    endgenerate

    always_comb begin
        s1_d           = '0;
        s1_d.set_idx   = bus.in_set;
        s1_d.tag       = bus.in_tag;
        s1_d.flags     = bus.in_flags;
        s1_d.hit_vec   = hit_vec;
        s1_d.inv_vec   = inv_vec;
        s1_d.evict_way = bus.in_evict_way;
    end

    // S2: way selection from the registered vectors.
    logic                inv_found;
    logic [WAY_BITS-1:0] inv_way;
    logic [WAY_BITS-1:0] hit_way;

    llc_rr_way_select u_inv_sel (
        .vec_i   (s1_q.inv_vec),
        .start_i (s1_q.evict_way),
        .found_o (inv_found),
        .way_o   (inv_way)
    );

    always_comb begin
        hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (s1_q.hit_vec[i]) begin
                hit_way = WAY_BITS'(i);
            end
        end
    end

    always_comb begin
        s2_d         = '0;
        s2_d.set_idx = s1_q.set_idx;
        s2_d.tag     = s1_q.tag;
        s2_d.flags   = s1_q.flags;
        if (is_bypass(s1_q.flags)) begin
            s2_d.way = '0;
        end else if (|s1_q.hit_vec) begin
            s2_d.hit = 1'b1;
            s2_d.way = hit_way;
        end else if (inv_found) begin
            s2_d.way         = inv_way;
            s2_d.empty_found = 1'b1;
        end else begin
            s2_d.way   = s1_q.evict_way;
            s2_d.evict = 1'b1;
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
        s2_valid_d = s2_valid_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
        end else if (s2_adv) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_fire) begin
                s1_q <= s1_d;
            end
            if (s1_adv) begin
                s2_q <= s2_d;
            end
            if (out_fire) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    // Tags within a set are unique, so two matching valid ways means corruption upstream.
    always_ff @(posedge clk) begin
        if (!rst && s1_valid_q) begin
            assert ($onehot0(s1_q.hit_vec))
                else $error("llc_lookup_stage: multiple ways hit");
        end
    end

    assign bus.out_valid       = s2_valid_q;
    assign bus.out_set         = s2_q.set_idx;
    assign bus.out_tag         = s2_q.tag;
    assign bus.out_flags       = s2_q.flags;
    assign bus.out_hit         = s2_q.hit;
    assign bus.out_way         = s2_q.way;
    assign bus.out_evict       = s2_q.evict;
    assign bus.out_empty_found = s2_q.empty_found;
    assign lookups_cnt         = cnt_q;

endmodule

// File: tb/tb_llc_lookup_stage.sv
// Scoreboard bench for llc_lookup_stage: directed lookups, random traffic with
// random backpressure, stall behaviour and mid-stream reset.
module tb_llc_lookup_stage;
    import llc_lookup_pkg::*;

    typedef struct {
        logic [SET_BITS-1:0]        set_idx;
        logic [TAG_BITS-1:0]        tag;
        logic [WAYS*TAG_BITS-1:0]   tags;
        logic [WAYS*STATE_BITS-1:0] states;
        logic [WAY_BITS-1:0]        evict;
        logic [FLAG_BITS-1:0]       flags;
    } txn_t;

    typedef struct {
        logic [SET_BITS-1:0]  set_idx;
        logic [TAG_BITS-1:0]  tag;
        logic [FLAG_BITS-1:0] flags;
        logic                 hit;
        logic [WAY_BITS-1:0]  way;
        logic                 evict;
        logic                 empty;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] lookups_cnt;

    llc_lookup_stage_if bus ();

    llc_lookup_stage dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .lookups_cnt (lookups_cnt)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_sent = 0;
    int   n_out = 0;
    logic saw_full = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input txn_t t);
        exp_t e;
        e.set_idx = t.set_idx;
        e.tag     = t.tag;
        e.flags   = t.flags;
        e.hit     = 1'b0;
        e.way     = '0;
        e.evict   = 1'b0;
        e.empty   = 1'b0;
        if (t.flags[6] || t.flags[5]) return e;
        for (int i = 0; i < WAYS; i++) begin
            if (t.tags[i*TAG_BITS +: TAG_BITS] == t.tag &&
                t.states[i*STATE_BITS +: STATE_BITS] != 3'd0) begin
                e.hit = 1'b1;
                e.way = 4'(i);
                return e;
            end
        end
        for (int k = 0; k < WAYS; k++) begin
            int w;
            w = (int'(t.evict) + k) % WAYS;
            if (t.states[w*STATE_BITS +: STATE_BITS] == 3'd0) begin
                e.empty = 1'b1;
                e.way   = 4'(w);
                return e;
            end
        end
        e.way   = t.evict;
        e.evict = 1'b1;
        return e;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        logic [9:0] base;
        int         mode;
        base      = 10'($urandom);
        mode      = $urandom_range(0, 3);
        t.set_idx = 9'($urandom);
        t.evict   = 4'($urandom);
        t.flags   = 7'($urandom);
        if ($urandom_range(0, 3) != 0) t.flags[6:5] = 2'b00;
        for (int i = 0; i < WAYS; i++) begin
            t.tags[i*TAG_BITS +: TAG_BITS] = {base, 4'(i)};
            if (mode == 0 || $urandom_range(0, 3) != 0)
                t.states[i*STATE_BITS +: STATE_BITS] = 3'($urandom_range(1, 7));
            else
                t.states[i*STATE_BITS +: STATE_BITS] = 3'd0;
        end
        if ($urandom_range(0, 1) == 1)
            t.tag = {base, 4'($urandom)};
        else
            t.tag = {base + 10'd1, 4'd0};
        return t;
    endfunction

    // Drive one entry starting just after a rising edge; returns just after the accepting edge.
    task automatic send(input txn_t t);
        int waited = 0;
        bus.in_valid     = 1'b1;
        bus.in_set       = t.set_idx;
        bus.in_tag       = t.tag;
        bus.in_tags      = t.tags;
        bus.in_states    = t.states;
        bus.in_evict_way = t.evict;
        bus.in_flags     = t.flags;
        @(negedge clk);
        while (!bus.in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            check_val("send_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            @(posedge clk);
            sb.push_back(model(t));
            n_sent++;
        end
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (sb.size() != 0 && cyc < 100) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check_val("drain", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor: every valid output is compared with the scoreboard head,
    // including each cycle it is held under backpressure.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.in_valid && !bus.in_ready && bus.out_valid && !bus.out_ready)
                    saw_full = 1'b1;
                if (bus.out_valid) begin
                    if (sb.size() == 0) begin
                        check_val("unexpected_out", 32'(bus.out_valid), 32'd0);
                    end else begin
                        check_val("out_set",   32'(bus.out_set),         32'(sb[0].set_idx));
                        check_val("out_tag",   32'(bus.out_tag),         32'(sb[0].tag));
                        check_val("out_flags", 32'(bus.out_flags),       32'(sb[0].flags));
                        check_val("out_hit",   32'(bus.out_hit),         32'(sb[0].hit));
                        check_val("out_way",   32'(bus.out_way),         32'(sb[0].way));
                        check_val("out_evict", 32'(bus.out_evict),       32'(sb[0].evict));
                        check_val("out_empty", 32'(bus.out_empty_found), 32'(sb[0].empty));
                        if (bus.out_ready) begin
                            void'(sb.pop_front());
                            n_out++;
                            $display("out #%0d way=%0d hit=%0d evict=%0d empty=%0d",
                                     n_out, bus.out_way, bus.out_hit, bus.out_evict,
                                     bus.out_empty_found);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        bus.in_valid     = 1'b0;
        bus.in_set       = '0;
        bus.in_tag       = '0;
        bus.in_tags      = '0;
        bus.in_states    = '0;
        bus.in_evict_way = '0;
        bus.in_flags     = '0;
        bus.out_ready    = 1'b1;
        rst              = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_cnt",       32'(lookups_cnt),   32'd0);
        @(posedge clk);
        #1;

        // Hit in way 5, everything else invalid; also checks two-cycle latency.
        t.set_idx = 9'h1A5; t.tag = 14'h123; t.evict = 4'd9; t.flags = 7'b0000100;
        t.tags = '0; t.states = '0;
        t.tags[5*TAG_BITS +: TAG_BITS] = 14'h123;
        t.states[5*STATE_BITS +: STATE_BITS] = 3'd2;
        send(t);
        @(negedge clk);
        check_val("lat_s1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check_val("lat_s2", 32'(bus.out_valid), 32'd1);
        @(posedge clk); #1;

        // Only way 2 invalid, search starts at 14 and must wrap.
        t.set_idx = 9'h022; t.tag = 14'h3FFF; t.evict = 4'd14; t.flags = 7'b0000010;
        for (int i = 0; i < WAYS; i++) begin
            t.tags[i*TAG_BITS +: TAG_BITS] = 14'(32'h200 + i);
            t.states[i*STATE_BITS +: STATE_BITS] = (i == 2) ? 3'd0 : 3'd1;
        end
        send(t);

        // All valid, no match: evict the pointer way.
        t.set_idx = 9'h077; t.tag = 14'h0001; t.evict = 4'd7; t.flags = 7'b0000001;
        for (int i = 0; i < WAYS; i++) begin
            t.tags[i*TAG_BITS +: TAG_BITS] = 14'(32'h40 + i);
            t.states[i*STATE_BITS +: STATE_BITS] = 3'd3;
        end
        send(t);

        // Flush resume bypasses a real hit in way 3.
        t.set_idx = 9'h133; t.tag = 14'h0055; t.evict = 4'd11; t.flags = 7'b0100000;
        t.tags[3*TAG_BITS +: TAG_BITS] = 14'h0055;
        t.states[3*STATE_BITS +: STATE_BITS] = 3'd1;
        send(t);

        // Eviction pointer at WAYS-1 with way 0 the only invalid way.
        t.set_idx = 9'h000; t.tag = 14'h2222; t.evict = 4'd15; t.flags = 7'b0001000;
        t.states[0 +: STATE_BITS] = 3'd0;
        send(t);
        wait_drain();
        check_val("cnt_directed", 32'(lookups_cnt), 32'(n_sent));

        // Five back-to-back entries under a multi-cycle stall.
        fork
            begin
                for (int i = 0; i < 5; i++) send(rand_txn());
            end
            begin
                @(posedge clk); #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        check_val("saw_full", 32'(saw_full), 32'd1);
        check_val("cnt_bp", 32'(lookups_cnt), 32'(n_sent));

        // Random traffic with random downstream readiness.
        fork
            begin
                for (int i = 0; i < 40; i++) send(rand_txn());
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk); #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        bus.out_ready = 1'b1;
        wait_drain();
        check_val("cnt_random", 32'(lookups_cnt), 32'(n_sent));

        // Reset with two entries stuck in the pipeline drops them.
        bus.out_ready = 1'b0;
        send(rand_txn());
        send(rand_txn());
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        n_sent = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_val("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check_val("mid_rst_cnt",       32'(lookups_cnt),   32'd0);
        @(posedge clk); #1;
        send(rand_txn());
        wait_drain();
        check_val("cnt_after_rst", 32'(lookups_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
